// File: rtl/fb_port_arbiter_pkg.sv
// Shared frame-buffer geometry, arbiter state encoding and EPP register map.
// The RMW merge and range check live here so every user agrees on them.
package fb_port_arbiter_pkg;

    localparam int unsigned WIDTH     = 320;
    localparam int unsigned HEIGHT    = 200;
    localparam int unsigned FB_DEPTH  = WIDTH * HEIGHT / 8;
    localparam int unsigned FB_ADDR_W = 13;
    localparam int unsigned ADDR_W    = FB_ADDR_W;

    localparam logic [FB_ADDR_W-1:0] FB_DEPTH_A = FB_ADDR_W'(FB_DEPTH);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRd    = 3'd1,
        StRmwRd = 3'd2,
        StRmwWr = 3'd3,
        StWrAck = 3'd4
    } arb_state_e;

    // EPP host register map
    localparam logic [2:0] EPP_REG_CTRL    = 3'd0;
    localparam logic [2:0] EPP_REG_ADDR_LO = 3'd1;
    localparam logic [2:0] EPP_REG_ADDR_HI = 3'd2;
    localparam logic [2:0] EPP_REG_DATA    = 3'd3;
    localparam logic [2:0] EPP_REG_STATUS  = 3'd4;

    function automatic logic addr_in_range(input logic [FB_ADDR_W-1:0] addr);
        return addr < FB_DEPTH_A;
    endfunction

    function automatic logic [7:0] rmw_merge(input logic [7:0] wdata,
                                             input logic [7:0] rdata,
                                             input logic [7:0] mask);
        return (wdata & mask) | (rdata & ~mask);
    endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester-side bus of the frame-buffer arbiter: EPP host port and engine port.
// slave = arbiter view, master = requester view.
interface fb_port_arbiter_if;
    import fb_port_arbiter_pkg::*;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic              host_ack;
    logic [7:0]        host_rdata;

    logic              eng_req;
    logic              eng_we;
    logic [ADDR_W-1:0] eng_addr;
    logic [7:0]        eng_wdata;
    logic [7:0]        eng_mask;
    logic              eng_ack;
    logic [7:0]        eng_rdata;

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        input  eng_req, eng_we, eng_addr, eng_wdata, eng_mask,
        output host_ack, host_rdata, eng_ack, eng_rdata
    );

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        output eng_req, eng_we, eng_addr, eng_wdata, eng_mask,
        input  host_ack, host_rdata, eng_ack, eng_rdata
    );

endinterface

// File: rtl/fb_port_arbiter_ram.sv
// Single-port frame-buffer RAM: registered read, output holds during writes.
// Out-of-range addresses neither write nor update the read register.
module fb_port_arbiter_ram
    import fb_port_arbiter_pkg::*;
(
    input  logic              uclk,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_we,
    input  logic [7:0]        ram_wdata,
    output logic [7:0]        ram_rdata
);

    logic [7:0] mem [FB_DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge uclk) begin
        if (addr_in_range(ram_addr)) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
            end else begin
                rdata_q <= mem[ram_addr];
            end
        end
    end

    assign ram_rdata = rdata_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Round-robin arbiter sequencing host and engine accesses to the frame-buffer RAM,
// including masked read-modify-write for partial engine writes.
module fb_port_arbiter
    import fb_port_arbiter_pkg::*;
(
    input  logic              uclk,
    input  logic              rst,
    fb_port_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              phase_q, phase_d;
    logic              sel_eng_q, sel_eng_d;
    logic              oor_q, oor_d;
    logic              last_host_q, last_host_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        mask_q, mask_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              host_ack_q, host_ack_d;
    logic              eng_ack_q, eng_ack_d;
    logic [7:0]        host_rdata_q, host_rdata_d;
    logic [7:0]        eng_rdata_q, eng_rdata_d;

    logic              host_ok, eng_ok, pick_eng, g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [7:0]        g_wdata, g_mask, rd_val;

    always_ff @(posedge uclk) begin
        if (rst) begin
            state_q      <= StIdle;
            phase_q      <= 1'b0;
            sel_eng_q    <= 1'b0;
            oor_q        <= 1'b0;
            last_host_q  <= 1'b0;
            wdata_q      <= 8'h00;
            mask_q       <= 8'h00;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= 8'h00;
            host_ack_q   <= 1'b0;
            eng_ack_q    <= 1'b0;
            host_rdata_q <= 8'h00;
            eng_rdata_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            sel_eng_q    <= sel_eng_d;
            oor_q        <= oor_d;
            last_host_q  <= last_host_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            host_ack_q   <= host_ack_d;
            eng_ack_q    <= eng_ack_d;
            host_rdata_q <= host_rdata_d;
            eng_rdata_q  <= eng_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        sel_eng_d    = sel_eng_q;
        oor_d        = oor_q;
        last_host_d  = last_host_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        ram_addr_d   = ram_addr_q;
        ram_we_d     = 1'b0;
        ram_wdata_d  = ram_wdata_q;
        host_ack_d   = 1'b0;
        eng_ack_d    = 1'b0;
        host_rdata_d = host_rdata_q;
        eng_rdata_d  = eng_rdata_q;

        // A port showing ack this cycle is masked so a held req is not granted twice.
        host_ok  = bus.host_req & ~host_ack_q;
        eng_ok   = bus.eng_req & ~eng_ack_q;
        pick_eng = eng_ok & (~host_ok | last_host_q);
        g_we     = pick_eng ? bus.eng_we    : bus.host_we;
        g_addr   = pick_eng ? bus.eng_addr  : bus.host_addr;
        g_wdata  = pick_eng ? bus.eng_wdata : bus.host_wdata;
        g_mask   = pick_eng ? bus.eng_mask  : 8'hFF;
        rd_val   = oor_q ? 8'h00 : ram_rdata;

        unique case (state_q)
            StIdle: begin
                if (host_ok | eng_ok) begin
                    last_host_d = ~pick_eng;
                    sel_eng_d   = pick_eng;
                    oor_d       = ~addr_in_range(g_addr);
                    wdata_d     = g_wdata;
                    mask_d      = g_mask;
                    ram_addr_d  = g_addr;
                    phase_d     = 1'b0;
                    if (oor_d || !g_we) begin
                        state_d = StRd;
                    end else if (g_mask == 8'hFF) begin
                        ram_we_d    = 1'b1;
                        ram_wdata_d = g_wdata;
                        state_d     = StWrAck;
                    end else if (g_mask == 8'h00) begin
                        state_d = StWrAck;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StRd: begin
                // First cycle waits for the RAM read register, second returns data.
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    state_d = StIdle;
                    if (sel_eng_q) begin
                        eng_ack_d   = 1'b1;
                        eng_rdata_d = rd_val;
                    end else begin
                        host_ack_d   = 1'b1;
                        host_rdata_d = rd_val;
                    end
                end
            end
            StRmwRd: begin
                state_d = StRmwWr;
            end
            StRmwWr: begin
                ram_we_d    = 1'b1;
                ram_wdata_d = rmw_merge(wdata_q, ram_rdata, mask_q);
                state_d     = StWrAck;
            end
            StWrAck: begin
                state_d    = StIdle;
                host_ack_d = ~sel_eng_q;
                eng_ack_d  = sel_eng_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ram_addr       = ram_addr_q;
    assign ram_we         = ram_we_q;
    assign ram_wdata      = ram_wdata_q;
    assign busy           = (state_q != StIdle);
    assign bus.host_ack   = host_ack_q;
    assign bus.host_rdata = host_rdata_q;
    assign bus.eng_ack    = eng_ack_q;
    assign bus.eng_rdata  = eng_rdata_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter with the frame-buffer RAM alongside it.
// Host uses words 0..7/20, engine 8..15, so per-port expectations are order-independent.
module tb_fb_port_arbiter;
    import fb_port_arbiter_pkg::*;

    logic              uclk = 1'b0;
    logic              rst  = 1'b1;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic              busy;

    fb_port_arbiter_if bus ();

    fb_port_arbiter u_dut (
        .uclk      (uclk),
        .rst       (rst),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    fb_port_arbiter_ram u_ram (
        .uclk      (uclk),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 uclk = ~uclk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         we_cnt = 0;
    int         we_exp = 0;
    logic [7:0] mem_m [0:8191];
    logic [7:0] host_rd_m = 8'h00;
    logic [7:0] eng_rd_m  = 8'h00;
    logic [7:0] host_q [$];
    logic [7:0] eng_q [$];
    int         ack_order [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents and last returned data per port.
    function automatic void exp_host(input logic we, input logic [12:0] a, input logic [7:0] wd);
        if (a >= 13'd8000) begin
            host_rd_m = 8'h00;
        end else if (!we) begin
            host_rd_m = mem_m[a];
        end else begin
            mem_m[a] = wd;
            we_exp++;
        end
        host_q.push_back(host_rd_m);
    endfunction

    function automatic void exp_eng(input logic we, input logic [12:0] a, input logic [7:0] wd,
                                    input logic [7:0] m);
        if (a >= 13'd8000) begin
            eng_rd_m = 8'h00;
        end else if (!we) begin
            eng_rd_m = mem_m[a];
        end else begin
            if (m != 8'h00) we_exp++;
            mem_m[a] = (wd & m) | (mem_m[a] & ~m);
        end
        eng_q.push_back(eng_rd_m);
    endfunction

    always @(negedge uclk) begin
        if (ram_we) we_cnt++;
        if (!rst) begin
            if (bus.host_ack && bus.eng_ack) check("dual_ack", 32'd1, 32'd0);
            if (bus.host_ack) begin
                ack_order.push_back(0);
                if (host_q.size() == 0) check("host_unexpected_ack", 32'd1, 32'd0);
                else check("host_rdata", 32'(bus.host_rdata), 32'(host_q.pop_front()));
            end
            if (bus.eng_ack) begin
                ack_order.push_back(1);
                if (eng_q.size() == 0) check("eng_unexpected_ack", 32'd1, 32'd0);
                else check("eng_rdata", 32'(bus.eng_rdata), 32'(eng_q.pop_front()));
            end
        end
    end

    task automatic host_txn(input logic we, input logic [12:0] a, input logic [7:0] wd,
                            output int lat);
        @(negedge uclk);
        bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = wd;
        exp_host(we, a, wd);
        lat = 0;
        do begin @(negedge uclk); lat++; end while (!bus.host_ack && lat < 60);
        if (!bus.host_ack) check("host_timeout", 32'd0, 32'd1);
        bus.host_req = 1'b0;
    endtask

    task automatic eng_txn(input logic we, input logic [12:0] a, input logic [7:0] wd,
                           input logic [7:0] m, output int lat);
        @(negedge uclk);
        bus.eng_req = 1'b1; bus.eng_we = we; bus.eng_addr = a; bus.eng_wdata = wd;
        bus.eng_mask = m;
        exp_eng(we, a, wd, m);
        lat = 0;
        do begin @(negedge uclk); lat++; end while (!bus.eng_ack && lat < 60);
        if (!bus.eng_ack) check("eng_timeout", 32'd0, 32'd1);
        bus.eng_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_host_ack"}, 32'(bus.host_ack), 32'd0);
        check({tag, "_eng_ack"}, 32'(bus.eng_ack), 32'd0);
        check({tag, "_host_rdata"}, 32'(bus.host_rdata), 32'd0);
        check({tag, "_eng_rdata"}, 32'(bus.eng_rdata), 32'd0);
        check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge uclk);
        rst = 1'b1;
        repeat (2) @(negedge uclk);
        rst = 1'b0;
        host_rd_m = 8'h00;
        eng_rd_m  = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        int lat;
        int w0;
        int n;
        int cyc;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = 8'h00;
        bus.eng_req = 0; bus.eng_we = 0; bus.eng_addr = '0; bus.eng_wdata = 8'h00;
        bus.eng_mask = 8'h00;
        repeat (3) @(negedge uclk);
        check_all_zero("reset");
        rst = 1'b0;

        // Preload the words used below through the host port.
        for (int i = 0; i < 16; i++) begin
            host_txn(1'b1, 13'(i), 8'($urandom_range(0, 255)), lat);
            if (i == 0) check("wr_latency", 32'(lat), 32'd2);
        end

        host_txn(1'b1, 13'd10, 8'h5A, lat);
        check("host_wr_latency", 32'(lat), 32'd2);
        host_txn(1'b0, 13'd10, 8'h00, lat);
        check("host_rd_latency", 32'(lat), 32'd3);

        host_txn(1'b1, 13'd20, 8'hA0, lat);
        w0 = we_cnt;
        eng_txn(1'b1, 13'd20, 8'hFF, 8'h0F, lat);
        check("rmw_latency", 32'(lat), 32'd4);
        check("rmw_we_pulses", 32'(we_cnt - w0), 32'd1);
        host_txn(1'b0, 13'd20, 8'h00, lat);
        check("rmw_model_value", 32'(mem_m[20]), 32'hAF);

        w0 = we_cnt;
        host_txn(1'b0, 13'd8000, 8'h00, lat);
        check("oor_rd_latency", 32'(lat), 32'd3);
        host_txn(1'b1, 13'd8100, 8'h77, lat);
        eng_txn(1'b1, 13'd8191, 8'h55, 8'h0F, lat);
        check("oor_no_we", 32'(we_cnt - w0), 32'd0);

        w0 = we_cnt;
        eng_txn(1'b1, 13'd11, 8'h3C, 8'h00, lat);
        check("mask0_latency", 32'(lat), 32'd2);
        check("mask0_no_we", 32'(we_cnt - w0), 32'd0);

        for (int i = 0; i < 4; i++) begin
            host_txn(1'b0, 13'(i), 8'h00, lat);
            check("b2b_rd_latency", 32'(lat), 32'd3);
        end

        // Concurrent randomized traffic from both ports.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int hl;
                    repeat ($urandom_range(0, 3)) @(negedge uclk);
                    host_txn(1'($urandom_range(0, 1)),
                             ($urandom_range(0, 9) == 0) ? 13'(8000 + $urandom_range(0, 191))
                                                         : 13'($urandom_range(0, 7)),
                             8'($urandom_range(0, 255)), hl);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    int el;
                    int r;
                    logic [7:0] m;
                    r = $urandom_range(0, 3);
                    m = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom_range(0, 255));
                    repeat ($urandom_range(0, 3)) @(negedge uclk);
                    eng_txn(1'($urandom_range(0, 1)),
                            ($urandom_range(0, 9) == 0) ? 13'(8000 + $urandom_range(0, 191))
                                                        : 13'(8 + $urandom_range(0, 7)),
                            8'($urandom_range(0, 255)), m, el);
                end
            end
        join

        // Both ports held continuously: grants must alternate, host first after reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_host(1'b0, 13'd3, 8'h00);
            exp_eng(1'b0, 13'd12, 8'h00, 8'h00);
        end
        ack_order.delete();
        @(negedge uclk);
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 13'd3;
        bus.eng_req = 1'b1; bus.eng_we = 1'b0; bus.eng_addr = 13'd12;
        n = 0;
        cyc = 0;
        while (n < 8 && cyc < 200) begin
            @(negedge uclk);
            cyc++;
            if (bus.host_ack || bus.eng_ack) n++;
        end
        bus.host_req = 1'b0;
        bus.eng_req = 1'b0;
        check("alt_ack_count", 32'(n), 32'd8);
        repeat (6) @(negedge uclk);
        check("alt_order_len", 32'(ack_order.size()), 32'd8);
        if (ack_order.size() == 8) begin
            check("alt_first_host", 32'(ack_order[0]), 32'd0);
            for (int i = 1; i < 8; i++) begin
                check("alt_alternates", 32'(ack_order[i] != ack_order[i-1]), 32'd1);
            end
        end

        // Reset while an RMW is in flight: abandoned with no write.
        host_txn(1'b1, 13'd9, 8'h00, lat);
        w0 = we_cnt;
        @(negedge uclk);
        bus.eng_req = 1'b1; bus.eng_we = 1'b1; bus.eng_addr = 13'd9;
        bus.eng_wdata = 8'hFF; bus.eng_mask = 8'h01;
        @(negedge uclk);
        check("rmw_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        bus.eng_req = 1'b0;
        @(negedge uclk);
        check_all_zero("midrst");
        rst = 1'b0;
        host_rd_m = 8'h00;
        eng_rd_m  = 8'h00;
        repeat (4) @(negedge uclk);
        check("midrst_no_we", 32'(we_cnt - w0), 32'd0);
        host_txn(1'b0, 13'd9, 8'h00, lat);

        repeat (5) @(negedge uclk);
        check("we_pulse_total", 32'(we_cnt), 32'(we_exp));
        check("host_q_drained", 32'(host_q.size()), 32'd0);
        check("eng_q_drained", 32'(eng_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
